dmc_dma_ctrl: RTL and testbench

Sequences DMC sample-fetch DMA and drives the shared APU address bus request signals (RUNDMC, n_DMCAB, DMCRDY, DMC_Addr) that the sprite DMA / address mux consume.
- Holds $4010/$4012/$4013 state, the sample address and length counters, CPU-halt handshake, the optional get/put alignment, and the DMC IRQ.
- Sits between the DMC sample-output unit (buffer-empty request) and the sprite DMA / address mux.

---
 rtl/dmc_dma_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dmc_dma_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmc_dma_ctrl.sv
// -----------------------------------------------------------------------------
// dmc_dma_ctrl
//   Sequences the DMC sample-fetch DMA. On a buffer-empty request it halts the
//   CPU (waiting for a read cycle, since writes cannot be stalled), spends one
//   dummy cycle, optionally one alignment cycle, then takes the address bus for
//   a single fetch cycle. Holds the $4010/$4012/$4013 registers, the sample
//   address/length counters and the DMC IRQ flag.
//
//   Optional feature (macro DMC_DMA_GET_ALIGN_EN): the fetch is forced onto a
//   "get" cycle (phase=1) by inserting one ALIGN cycle after DUMMY when needed.
//   Without the macro DUMMY always goes straight to FETCH and no phase flop
//   exists.
//
// Ports
//   ACLK        clock, one rising edge per CPU cycle
//   RES         asynchronous active-high reset
//   RnW         CPU direction of the current cycle (1 = read)
//   W4010       $4010 write strobe: DB[7] IRQ enable, DB[6] loop
//   W4012       $4012 write strobe: sample start address
//   W4013       $4013 write strobe: sample length
//   W4015       $4015 write strobe: DB[4] DMC enable, always clears DMC_INT
//   DB[7:0]     register write data / fetched sample byte
//   BufEmpty    sample buffer empty, fetch requested
//   RUNDMC      DMA sequence active (freezes sprite DMA)
//   n_DMCAB     0 while DMC owns the address bus (fetch cycle)
//   DMCRDY      0 while the CPU is stalled for DMC
//   DMC_Addr    current sample address
//   SampleBuf   last fetched byte
//   SampleLoad  one-cycle pulse after SampleBuf was updated
//   DMC_INT     DMC IRQ flag
//   DMC_Active  remaining length != 0
// -----------------------------------------------------------------------------
module dmc_dma_ctrl #(
    parameter logic [15:0] ADDR_BASE = 16'hC000,
    parameter logic [15:0] WRAP_ADDR = 16'h8000,
    parameter int          LEN_SHIFT = 4
) (
    input  logic        ACLK,
    input  logic        RES,
    input  logic        RnW,
    input  logic        W4010,
    input  logic        W4012,
    input  logic        W4013,
    input  logic        W4015,
    input  logic [7:0]  DB,
    input  logic        BufEmpty,
    output logic        RUNDMC,
    output logic        n_DMCAB,
    output logic        DMCRDY,
    output logic [15:0] DMC_Addr,
    output logic [7:0]  SampleBuf,
    output logic        SampleLoad,
    output logic        DMC_INT,
    output logic        DMC_Active
);

    // Wide enough for ($FF << LEN_SHIFT) + 1 without overflow.
    localparam int LW = 8 + LEN_SHIFT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_DUMMY,
        S_ALIGN,
        S_FETCH
    } state_t;

    state_t        state, state_next;
    logic          irq_en, loop_en;
    logic [7:0]    addr_reg, len_reg;
    logic [LW-1:0] length, length_next;
    logic [15:0]   addr_next, addr_inc, start_addr;
    logic [LW-1:0] start_len;
    logic          fetch_done, last_fetch, dma_disable, enable_reload;
    logic          irq_set, irq_clr;

`ifdef DMC_DMA_GET_ALIGN_EN
    // phase=1 marks a "get" cycle; toggles on every edge out of reset.
    logic phase;

    always_ff @(posedge ACLK or posedge RES) begin
        if (RES) phase <= 1'b0;
        else     phase <= ~phase;
    end
`endif

    // ---------------- FSM: next state and bus-control outputs ----------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can
        // leave one unassigned and infer a latch.
        state_next = state;
        RUNDMC     = 1'b1;
        DMCRDY     = 1'b0;
        n_DMCAB    = 1'b1;
        case (state)
            S_IDLE: begin
                RUNDMC = 1'b0;
                DMCRDY = 1'b1;
                if (BufEmpty && (length != '0)) state_next = S_HALT;
            end
            // A CPU write cannot be stalled: wait for the first read cycle.
            S_HALT:  if (RnW) state_next = S_DUMMY;
`ifdef DMC_DMA_GET_ALIGN_EN
            // Phase flips on the DUMMY exit edge, so phase=0 now means the
            // next cycle is a get cycle.
            S_DUMMY: state_next = phase ? S_ALIGN : S_FETCH;
`else
            S_DUMMY: state_next = S_FETCH;
`endif
            S_ALIGN: state_next = S_FETCH;
            S_FETCH: begin
                n_DMCAB    = 1'b0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- address / length counters ----------------
    assign fetch_done    = (state == S_FETCH);
    assign last_fetch    = fetch_done && (length == LW'(1));
    assign dma_disable   = W4015 && !DB[4];
    assign enable_reload = W4015 && DB[4] && (length == '0);
    assign start_addr    = ADDR_BASE + {2'b00, addr_reg, 6'b000000};
    assign start_len     = (LW'(len_reg) << LEN_SHIFT) + LW'(1);
    assign addr_inc      = (DMC_Addr == 16'hFFFF) ? WRAP_ADDR : DMC_Addr + 16'd1;

    always_comb begin
        addr_next   = DMC_Addr;
        length_next = length;
        if (fetch_done) begin
            addr_next = addr_inc;
            // Length may already be 0 if the channel was disabled mid-sequence.
            if (length != '0) length_next = length - LW'(1);
        end
        // A disable on the final fetch suppresses the loop reload; an enable
        // write on an idle channel overrides whatever the fetch computed.
        if ((last_fetch && loop_en && !dma_disable) || enable_reload) begin
            addr_next   = start_addr;
            length_next = start_len;
        end
        if (dma_disable) length_next = '0;
    end

    // Register writes on the same edge take priority over setting the IRQ.
    assign irq_set = last_fetch && !loop_en && irq_en;
    assign irq_clr = W4015 || (W4010 && !DB[7]);

    // ---------------- state registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge ACLK or posedge RES) begin
        if (RES) begin
            state      <= S_IDLE;
            length     <= '0;
            DMC_Addr   <= ADDR_BASE;
            DMC_Active <= 1'b0;
            SampleBuf  <= 8'h00;
            SampleLoad <= 1'b0;
            DMC_INT    <= 1'b0;
            irq_en     <= 1'b0;
            loop_en    <= 1'b0;
            addr_reg   <= 8'h00;
            len_reg    <= 8'h00;
        end else begin
            state      <= state_next;
            length     <= length_next;
            DMC_Addr   <= addr_next;
            DMC_Active <= (length_next != '0);
            SampleLoad <= fetch_done;
            if (fetch_done) SampleBuf <= DB;
            if (W4010) begin
                irq_en  <= DB[7];
                loop_en <= DB[6];
            end
            if (W4012) addr_reg <= DB;
            if (W4013) len_reg  <= DB;
            if (irq_clr)      DMC_INT <= 1'b0;
            else if (irq_set) DMC_INT <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmc_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmc_dma_ctrl
//   Directed scenarios plus randomized traffic for dmc_dma_ctrl. The reference
//   model tracks the DMA sequence by absolute cycle numbers (when the halt ends
//   and in which cycle the fetch lands) and the counters as plain integers.
//   Outputs are sampled on the falling edge; inputs change just after it.
// -----------------------------------------------------------------------------
module tb_dmc_dma_ctrl;

    logic        ACLK = 1'b0;
    logic        RES, RnW, W4010, W4012, W4013, W4015, BufEmpty;
    logic [7:0]  DB;
    logic        RUNDMC, n_DMCAB, DMCRDY, SampleLoad, DMC_INT, DMC_Active;
    logic [15:0] DMC_Addr;
    logic [7:0]  SampleBuf;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef DMC_DMA_GET_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    always #5 ACLK = ~ACLK;

    dmc_dma_ctrl dut (
        .ACLK       (ACLK),
        .RES        (RES),
        .RnW        (RnW),
        .W4010      (W4010),
        .W4012      (W4012),
        .W4013      (W4013),
        .W4015      (W4015),
        .DB         (DB),
        .BufEmpty   (BufEmpty),
        .RUNDMC     (RUNDMC),
        .n_DMCAB    (n_DMCAB),
        .DMCRDY     (DMCRDY),
        .DMC_Addr   (DMC_Addr),
        .SampleBuf  (SampleBuf),
        .SampleLoad (SampleLoad),
        .DMC_INT    (DMC_INT),
        .DMC_Active (DMC_Active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_cyc;        // cycles since reset release; phase of cycle k is k%2
    bit m_run;        // a DMA sequence occupies the current cycle
    bit m_wait;       // still halted, waiting for a CPU read cycle
    int m_fetch_at;   // absolute cycle of the fetch once the halt has ended
    int m_addr, m_len, m_sbuf, m_areg, m_lreg;
    bit m_irq, m_load, m_act, m_irq_en, m_loop;

    task automatic model_reset();
        m_cyc = 0; m_run = 0; m_wait = 0; m_fetch_at = 0;
        m_addr = 16'hC000; m_len = 0; m_sbuf = 0; m_areg = 0; m_lreg = 0;
        m_irq = 0; m_load = 0; m_act = 0; m_irq_en = 0; m_loop = 0;
    endtask

    function automatic bit model_fetching();
        return m_run && !m_wait && (m_cyc == m_fetch_at);
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        bit fetch_now, last, dis, en_rl;
        int n_addr, n_len, start_a, start_l, dummy_cyc;
        fetch_now = model_fetching();
        last      = fetch_now && (m_len == 1);
        dis       = W4015 && !DB[4];
        en_rl     = W4015 && DB[4] && (m_len == 0);
        start_a   = (16'hC000 + m_areg * 64) & 16'hFFFF;
        start_l   = m_lreg * 16 + 1;

        if (!m_run) begin
            if (BufEmpty && m_len != 0) begin
                m_run = 1; m_wait = 1;
            end
        end else if (m_wait) begin
            if (RnW) begin
                m_wait     = 0;
                dummy_cyc  = m_cyc + 1;
                m_fetch_at = dummy_cyc + 1;
                if (ALIGN && (m_fetch_at % 2 == 0)) m_fetch_at++;
            end
        end else if (fetch_now) begin
            m_run = 0;
        end

        n_addr = m_addr;
        n_len  = m_len;
        if (fetch_now) begin
            n_addr = (m_addr == 16'hFFFF) ? 16'h8000 : m_addr + 1;
            if (m_len > 0) n_len = m_len - 1;
        end
        if ((last && m_loop && !dis) || en_rl) begin
            n_addr = start_a; n_len = start_l;
        end
        if (dis) n_len = 0;

        if (W4015 || (W4010 && !DB[7])) m_irq = 0;
        else if (last && !m_loop && m_irq_en) m_irq = 1;

        m_load = fetch_now;
        if (fetch_now) m_sbuf = DB;
        if (W4010) begin m_irq_en = DB[7]; m_loop = DB[6]; end
        if (W4012) m_areg = DB;
        if (W4013) m_lreg = DB;
        m_addr = n_addr;
        m_len  = n_len;
        m_act  = (n_len != 0);
        m_cyc++;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".RUNDMC"},     RUNDMC,     m_run);
        check({tag, ".DMCRDY"},     DMCRDY,     !m_run);
        check({tag, ".n_DMCAB"},    n_DMCAB,    !model_fetching());
        check({tag, ".DMC_Addr"},   DMC_Addr,   m_addr);
        check({tag, ".SampleBuf"},  SampleBuf,  m_sbuf);
        check({tag, ".SampleLoad"}, SampleLoad, m_load);
        check({tag, ".DMC_INT"},    DMC_INT,    m_irq);
        check({tag, ".DMC_Active"}, DMC_Active, m_act);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        RnW = 1'b1; W4010 = 1'b0; W4012 = 1'b0; W4013 = 1'b0; W4015 = 1'b0;
        BufEmpty = 1'b0; DB = 8'h00;
    endtask

    task automatic step(input string tag);
        @(posedge ACLK);
        model_step();
        @(negedge ACLK);
        compare_all(tag);
    endtask

    task automatic apply_reset();
        RES = 1'b1;
        set_idle();
        @(negedge ACLK);
        @(negedge ACLK);
        model_reset();
        RES = 1'b0;
        compare_all("reset");
    endtask

    // which: 0=$4010, 2=$4012, 3=$4013, 5=$4015
    task automatic wr(input int which, input logic [7:0] v);
        set_idle();
        DB = v;
        case (which)
            0: W4010 = 1'b1;
            2: W4012 = 1'b1;
            3: W4013 = 1'b1;
            default: W4015 = 1'b1;
        endcase
        step("wr");
        set_idle();
    endtask

    // Request one DMA, hold RnW=0 for 'hold' halt cycles, and return the
    // 1-based position of the fetch cycle counted from the first HALT cycle.
    task automatic run_dma(input int hold, input logic [7:0] data,
                           input bit dis_in_fetch, output int pos);
        int start_cyc, exp_pos;
        pos = 0;
        set_idle();
        BufEmpty = 1'b1;
        step("req");
        BufEmpty  = 1'b0;
        start_cyc = m_cyc;
        for (int i = 1; i <= 12 && pos == 0; i++) begin
            RnW = (i <= hold) ? 1'b0 : 1'b1;
            DB  = data;
            if (i <= hold) check("halt.DMCRDY", DMCRDY, 1'b0);
            if (!n_DMCAB) begin
                pos = i;
                if (dis_in_fetch) W4015 = 1'b1;
            end
            step("dma");
        end
        set_idle();
        exp_pos = hold + 3;
        if (ALIGN && ((start_cyc + hold + 2) % 2 == 0)) exp_pos++;
        check("dma.fetch_pos", pos, exp_pos);
`ifdef DMC_DMA_GET_ALIGN_EN
        check("dma.get_phase", (start_cyc + pos - 1) % 2, 1);
`endif
    endtask

    initial begin
        int pos, r;

        apply_reset();

        // 1: basic fetch from $C000 with length 17
        wr(2, 8'h00); wr(3, 8'h01); wr(5, 8'h10);
        check("t1.addr", DMC_Addr, 16'hC000);
        check("t1.active", DMC_Active, 1'b1);
        run_dma(0, 8'h5A, 1'b0, pos);
        check("t1.load", SampleLoad, 1'b1);
        check("t1.buf", SampleBuf, 8'h5A);
        check("t1.addr_inc", DMC_Addr, 16'hC001);
        step("t1.after");
        check("t1.load_once", SampleLoad, 1'b0);

        // 2: writes delay the halt; fetch lands on both phases
        run_dma(3, 8'hA5, 1'b0, pos);
        for (int h = 0; h < 4; h++) run_dma(h, 8'(8'h30 + h), 1'b0, pos);

        // 3: address wrap past $FFFF and end-of-sample IRQ
        wr(5, 8'h00); wr(2, 8'hFF); wr(3, 8'h04); wr(0, 8'h80); wr(5, 8'h10);
        check("t3.start", DMC_Addr, 16'hFFC0);
        for (int i = 0; i < 63; i++) run_dma(0, 8'(i), 1'b0, pos);
        check("t3.at_ffff", DMC_Addr, 16'hFFFF);
        run_dma(0, 8'hEE, 1'b0, pos);
        check("t3.wrap", DMC_Addr, 16'h8000);
        check("t3.active_1", DMC_Active, 1'b1);
        check("t3.no_irq_yet", DMC_INT, 1'b0);
        run_dma(0, 8'hEF, 1'b0, pos);
        check("t3.irq", DMC_INT, 1'b1);
        check("t3.inactive", DMC_Active, 1'b0);
        wr(0, 8'h80);
        check("t3.irq_kept", DMC_INT, 1'b1);
        wr(0, 8'h00);
        check("t3.irq_clr4010", DMC_INT, 1'b0);

        // 4: loop reload from registers
        wr(2, 8'h00); wr(3, 8'h00); wr(0, 8'hC0); wr(5, 8'h00); wr(5, 8'h10);
        wr(3, 8'h01);
        run_dma(0, 8'h11, 1'b0, pos);
        check("t4.reload_addr", DMC_Addr, 16'hC000);
        check("t4.active", DMC_Active, 1'b1);
        check("t4.no_irq", DMC_INT, 1'b0);
        for (int i = 0; i < 16; i++) run_dma(0, 8'h22, 1'b0, pos);
        check("t4.len17_addr", DMC_Addr, 16'hC010);
        run_dma(0, 8'h33, 1'b0, pos);
        check("t4.reload2", DMC_Addr, 16'hC000);

        // 5: disable during FETCH
        wr(0, 8'h80); wr(5, 8'h00); wr(5, 8'h10);
        run_dma(1, 8'h2C, 1'b1, pos);
        check("t5.load", SampleLoad, 1'b1);
        check("t5.buf", SampleBuf, 8'h2C);
        check("t5.inactive", DMC_Active, 1'b0);
        check("t5.no_irq", DMC_INT, 1'b0);
        set_idle();
        BufEmpty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("t5.ignored");
            check("t5.no_run", RUNDMC, 1'b0);
        end
        set_idle();

        // 6: asynchronous reset during DUMMY
        wr(2, 8'h05); wr(3, 8'h01); wr(5, 8'h10);
        BufEmpty = 1'b1;
        step("t6.req");
        BufEmpty = 1'b0;
        step("t6.halt");
        check("t6.in_dummy", RUNDMC, 1'b1);
        #2 RES = 1'b1;
        #1;
        check("t6.async_run", RUNDMC, 1'b0);
        check("t6.async_rdy", DMCRDY, 1'b1);
        check("t6.async_ab", n_DMCAB, 1'b1);
        check("t6.async_addr", DMC_Addr, 16'hC000);
        check("t6.async_act", DMC_Active, 1'b0);
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step("t6.post");
            check("t6.no_load", SampleLoad, 1'b0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            set_idle();
            RnW      = ($urandom_range(0, 3) != 0);
            BufEmpty = ($urandom_range(0, 2) == 0);
            DB       = 8'($urandom_range(0, 255));
            r        = $urandom_range(0, 59);
            case (r)
                0: W4010 = 1'b1;
                1: begin W4012 = 1'b1; if ($urandom_range(0, 1) == 0) DB = 8'hFF; end
                2: begin W4013 = 1'b1; DB = 8'($urandom_range(0, 2)); end
                3, 4, 5: begin W4015 = 1'b1; DB[4] = ($urandom_range(0, 3) != 0); end
                default: ;
            endcase
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
